// File: rtl/spi_pts_frame.sv
`default_nettype none
// ============================================================================
// Module   : spi_pts_frame
// Purpose  : Parallel-to-serial SPI frame shifter. Loads a word over a
//            valid/ready handshake, shifts one bit per shift_en strobe onto
//            dout, and pulses done when the frame completes.
// Options  : SPI_PTS_PREFETCH_EN adds a one-word holding register so that
//            consecutive frames can run back-to-back.
// Revision : 1.0 - initial release
// ============================================================================
module spi_pts_frame #(
    parameter int unsigned WIDTH      = 6,
    parameter bit          MSB_FIRST  = 1'b1,
    parameter bit          IDLE_LEVEL = 1'b0,
    parameter bit          FILL_BIT   = 1'b0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         load_valid,
    output logic                         load_ready,
    input  logic [WIDTH-1:0]             load_data,
    input  logic                         shift_en,
    input  logic                         abort,
    output logic                         dout,
    output logic                         busy,
    output logic                         done,
    output logic [$clog2(WIDTH+1)-1:0]   bit_cnt
);

    localparam int unsigned            CNT_W     = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0]       LAST_CNT  = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0]       FILL_WORD = {WIDTH{FILL_BIT}};

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   sr_q, sr_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic               dout_q, dout_d;
    logic               done_q, done_d;

    logic [WIDTH-1:0]   sr_shifted;
    logic               sr_out_d;
    logic               accept;
    logic               strobe;
    logic               final_strobe;

`ifdef SPI_PTS_PREFETCH_EN
    logic [WIDTH-1:0]   hold_q, hold_d;
    logic               hold_full_q, hold_full_d;

    assign load_ready = !abort && !hold_full_q;
`else
    assign load_ready = !abort && (state_q == ST_IDLE);
`endif

    // Shift direction: the output end is the MSB or LSB, fill enters opposite.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign sr_shifted = {sr_q[WIDTH-2:0], FILL_BIT};
            assign sr_out_d   = sr_d[WIDTH-1];
        end else begin : g_lsb_first
            assign sr_shifted = {FILL_BIT, sr_q[WIDTH-1:1]};
            assign sr_out_d   = sr_d[0];
        end
    endgenerate

    assign accept       = load_valid && load_ready;
    assign strobe       = shift_en && (state_q == ST_SHIFT);
    assign final_strobe = strobe && (bit_cnt_q == LAST_CNT);

    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        bit_cnt_d = bit_cnt_q;
        done_d    = 1'b0;
`ifdef SPI_PTS_PREFETCH_EN
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
`endif

        if (abort) begin
            state_d   = ST_IDLE;
            sr_d      = FILL_WORD;
            bit_cnt_d = '0;
`ifdef SPI_PTS_PREFETCH_EN
            hold_full_d = 1'b0;
`endif
        end else if (final_strobe) begin
            done_d    = 1'b1;
            bit_cnt_d = '0;
`ifdef SPI_PTS_PREFETCH_EN
            if (hold_full_q) begin
                sr_d        = hold_q;
                hold_full_d = 1'b0;
                state_d     = ST_SHIFT;
            end else if (accept) begin
                sr_d    = load_data;
                state_d = ST_SHIFT;
            end else begin
                sr_d    = sr_shifted;
                state_d = ST_IDLE;
            end
`else
            sr_d    = sr_shifted;
            state_d = ST_IDLE;
`endif
        end else begin
            if (strobe) begin
                sr_d      = sr_shifted;
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
            // A load in IDLE overrides any strobe seen in the same cycle.
            if (accept) begin
                if (state_q == ST_IDLE) begin
                    sr_d      = load_data;
                    bit_cnt_d = '0;
                    state_d   = ST_SHIFT;
                end
`ifdef SPI_PTS_PREFETCH_EN
                else begin
                    hold_d      = load_data;
                    hold_full_d = 1'b1;
                end
`endif
            end
        end
    end

    // dout is registered from next-state values so it changes with the frame.
    always_comb begin
        dout_d = IDLE_LEVEL;
        if (state_d == ST_SHIFT) begin
            dout_d = sr_out_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            sr_q      <= FILL_WORD;
            bit_cnt_q <= '0;
            dout_q    <= IDLE_LEVEL;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            bit_cnt_q <= bit_cnt_d;
            dout_q    <= dout_d;
            done_q    <= done_d;
        end
    end

`ifdef SPI_PTS_PREFETCH_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q      <= '0;
            hold_full_q <= 1'b0;
        end else begin
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
        end
    end
`endif

    assign dout    = dout_q;
    assign busy    = (state_q == ST_SHIFT);
    assign done    = done_q;
    assign bit_cnt = bit_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_pts_frame.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_pts_frame
// Purpose  : Self-checking bench for spi_pts_frame (MSB- and LSB-first copies).
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_pts_frame;

    localparam int W  = 6;
    localparam int CW = $clog2(W + 1);
`ifdef SPI_PTS_PREFETCH_EN
    localparam bit PF = 1'b1;
`else
    localparam bit PF = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst, load_valid, shift_en, abort;
    logic [W-1:0]  load_data;
    logic          rdy_m, dout_m, busy_m, done_m;
    logic          rdy_l, dout_l, busy_l, done_l;
    logic [CW-1:0] cnt_m, cnt_l;

    always #5 clk = ~clk;

    spi_pts_frame #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0), .FILL_BIT(1'b0)) u_dut_msb (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(rdy_m),
        .load_data(load_data), .shift_en(shift_en), .abort(abort),
        .dout(dout_m), .busy(busy_m), .done(done_m), .bit_cnt(cnt_m)
    );

    spi_pts_frame #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0), .FILL_BIT(1'b0)) u_dut_lsb (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(rdy_l),
        .load_data(load_data), .shift_en(shift_en), .abort(abort),
        .dout(dout_l), .busy(busy_l), .done(done_l), .bit_cnt(cnt_l)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model: frame word plus count of bits already sent.
    bit           m_busy, m_done, m_hold_full;
    logic [W-1:0] m_word, m_hold;
    int           m_n;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic bit m_ready(input bit ab);
        return !ab && (PF ? !m_hold_full : !m_busy);
    endfunction

    task automatic tick(input bit r, input bit lv, input logic [W-1:0] ld, input bit se, input bit ab);
        bit acc, exp_rdy;
        bit e_dm, e_dl;
        rst = r; load_valid = lv; load_data = ld; shift_en = se; abort = ab;
        #1;
        exp_rdy = m_ready(ab);
        if (!r) begin
            check("ready_msb", {31'd0, rdy_m}, {31'd0, exp_rdy});
            check("ready_lsb", {31'd0, rdy_l}, {31'd0, exp_rdy});
        end
        acc = lv && exp_rdy;
        @(posedge clk);
        if (r || ab) begin
            m_busy = 0; m_n = 0; m_done = 0; m_hold_full = 0;
        end else begin
            m_done = 0;
            if (m_busy && se && m_n == W - 1) begin
                m_done = 1;
                m_n    = 0;
                if (m_hold_full) begin
                    m_word = m_hold; m_hold_full = 0;
                end else if (acc) begin
                    m_word = ld;
                end else begin
                    m_busy = 0;
                end
            end else begin
                if (m_busy && se) m_n++;
                if (acc) begin
                    if (!m_busy) begin
                        m_word = ld; m_n = 0; m_busy = 1;
                    end else begin
                        m_hold = ld; m_hold_full = 1;
                    end
                end
            end
        end
        #1;
        cyc++;
        e_dm = m_busy ? m_word[W-1-m_n] : 1'b0;
        e_dl = m_busy ? m_word[m_n]     : 1'b0;
        check("dout_msb", {31'd0, dout_m}, {31'd0, e_dm});
        check("dout_lsb", {31'd0, dout_l}, {31'd0, e_dl});
        check("busy_msb", {31'd0, busy_m}, {31'd0, m_busy});
        check("busy_lsb", {31'd0, busy_l}, {31'd0, m_busy});
        check("done_msb", {31'd0, done_m}, {31'd0, m_done});
        check("done_lsb", {31'd0, done_l}, {31'd0, m_done});
        check("cnt_msb", 32'(cnt_m), 32'(m_n));
        check("cnt_lsb", 32'(cnt_l), 32'(m_n));
    endtask

    typedef struct {
        bit           lv;
        logic [W-1:0] ld;
        bit           se;
        bit           ab;
        bit           e_busy;
        bit           e_done;
        int           e_cnt;
        bit           e_dm;
        bit           e_dl;
    } vec_t;

    function automatic vec_t mk(bit lv, logic [W-1:0] ld, bit se, bit ab,
                                bit eb, bit ed, int ec, bit edm, bit edl);
        vec_t v;
        v.lv = lv; v.ld = ld; v.se = se; v.ab = ab;
        v.e_busy = eb; v.e_done = ed; v.e_cnt = ec; v.e_dm = edm; v.e_dl = edl;
        return v;
    endfunction

    vec_t tbl[12];

    initial begin
        logic [W-1:0] w;
        logic [11:0]  ab_exp;
        logic [11:0]  ab_got;
        int           n_done, n_busy_lo;

        m_busy = 0; m_done = 0; m_hold_full = 0; m_word = '0; m_hold = '0; m_n = 0;
        rst = 1; load_valid = 0; load_data = '0; shift_en = 0; abort = 0;

        // Reset held three cycles
        for (int i = 0; i < 3; i++) tick(1, 0, '0, 0, 0);
        tick(0, 0, '0, 0, 0);
        check("rst_dout", {31'd0, dout_m}, 32'd0);
        check("rst_busy", {31'd0, busy_m}, 32'd0);
        check("rst_done", {31'd0, done_m}, 32'd0);
        check("rst_ready", {31'd0, rdy_m}, 32'd1);
        check("rst_cnt", 32'(cnt_m), 32'd0);

        // Word 101100: MSB order 1,0,1,1,0,0; LSB order 0,0,1,1,0,1
        tbl[0]  = mk(1, 6'b101100, 0, 0, 1, 0, 0, 1, 0);
        tbl[1]  = mk(0, 6'b000000, 1, 0, 1, 0, 1, 0, 0);
        tbl[2]  = mk(0, 6'b000000, 0, 0, 1, 0, 1, 0, 0);
        tbl[3]  = mk(0, 6'b000000, 1, 0, 1, 0, 2, 1, 1);
        tbl[4]  = mk(0, 6'b000000, 1, 0, 1, 0, 3, 1, 1);
        tbl[5]  = mk(0, 6'b000000, 1, 0, 1, 0, 4, 0, 0);
        tbl[6]  = mk(0, 6'b000000, 1, 0, 1, 0, 5, 0, 1);
        tbl[7]  = mk(0, 6'b000000, 0, 0, 1, 0, 5, 0, 1);
        tbl[8]  = mk(0, 6'b000000, 1, 0, 0, 1, 0, 0, 0);
        tbl[9]  = mk(0, 6'b000000, 0, 0, 0, 0, 0, 0, 0);
        tbl[10] = mk(1, 6'b000011, 1, 0, 1, 0, 0, 0, 1);
        tbl[11] = mk(0, 6'b000000, 0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 12; i++) begin
            tick(0, tbl[i].lv, tbl[i].ld, tbl[i].se, tbl[i].ab);
            check("tbl_busy", {31'd0, busy_m}, {31'd0, tbl[i].e_busy});
            check("tbl_done", {31'd0, done_m}, {31'd0, tbl[i].e_done});
            check("tbl_cnt",  32'(cnt_m), 32'(tbl[i].e_cnt));
            check("tbl_dm",   {31'd0, dout_m}, {31'd0, tbl[i].e_dm});
            check("tbl_dl",   {31'd0, dout_l}, {31'd0, tbl[i].e_dl});
        end

        // Strobes four clocks apart
        w = 6'b101100;
        tick(0, 1, w, 0, 0);
        for (int k = 0; k < 6; k++) begin
            check("t2_dout", {31'd0, dout_m}, {31'd0, w[5-k]});
            for (int j = 0; j < 3; j++) tick(0, 0, '0, 0, 0);
            tick(0, 0, '0, 1, 0);
        end
        check("t2_done", {31'd0, done_m}, 32'd1);
        check("t2_busy", {31'd0, busy_m}, 32'd0);
        tick(0, 0, '0, 0, 0);
        check("t2_done_clr", {31'd0, done_m}, 32'd0);

        // Abort mid-frame, then a clean frame
        tick(0, 1, 6'b010101, 0, 0);
        for (int k = 0; k < 3; k++) tick(0, 0, '0, 1, 0);
        tick(0, 0, '0, 0, 1);
        check("t4_done", {31'd0, done_m}, 32'd0);
        check("t4_busy", {31'd0, busy_m}, 32'd0);
        check("t4_dout", {31'd0, dout_m}, 32'd0);
        tick(0, 1, 6'b111111, 0, 0);
        check("t4_cnt0", 32'(cnt_m), 32'd0);
        for (int k = 0; k < 6; k++) begin
            tick(0, 0, '0, 1, 0);
            if (k < 5) begin
                check("t4_dout1", {31'd0, dout_m}, 32'd1);
                check("t4_cnt", 32'(cnt_m), 32'(k + 1));
            end else begin
                check("t4_fin_done", {31'd0, done_m}, 32'd1);
            end
        end
        tick(0, 0, '0, 0, 0);

`ifdef SPI_PTS_PREFETCH_EN
        // Back-to-back frames through the holding register
        ab_exp = 12'b101010_010101;
        tick(0, 1, 6'h2A, 0, 0);
        ab_got[11] = dout_m;
        tick(0, 1, 6'h15, 1, 0);
        check("t6_ready_lo", {31'd0, rdy_m}, 32'd0);
        ab_got[10] = dout_m;
        n_done = 0; n_busy_lo = 0;
        for (int k = 2; k < 12; k++) begin
            tick(0, 0, '0, 1, 0);
            ab_got[11-k] = dout_m;
            if (done_m) n_done++;
            if (!busy_m) n_busy_lo++;
        end
        tick(0, 0, '0, 1, 0);
        if (done_m) n_done++;
        check("t6_bits", 32'(ab_got), 32'(ab_exp));
        check("t6_dones", 32'(n_done), 32'd2);
        check("t6_busy_gap", 32'(n_busy_lo), 32'd0);
        check("t6_end_busy", {31'd0, busy_m}, 32'd0);
        tick(0, 0, '0, 0, 0);
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            tick($urandom_range(0, 99) == 0,
                 1'($urandom),
                 W'($urandom),
                 $urandom_range(0, 2) == 0,
                 $urandom_range(0, 39) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
